// File: rtl/ex_stage_muldiv_if.sv
// ex_stage_muldiv_if: ID/EX -> EX -> EX/MEM signal bundle for ex_stage_muldiv.
//
// Optional feature macro: OVERFLOW_TRAP_EN (adds exmem_ovf).
//
// Ports (grouped by direction as seen from the execute stage):
//   inputs  : ex_flush, rd1, rd2, sign_ext, funct_code, wr_reg_in, alu_op,
//             alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch
//   outputs : ex_stall, exmem_result, exmem_r15, exmem_r15_we, exmem_store,
//             exmem_zero, exmem_wr_reg, exmem_mem_to_reg, exmem_reg_write,
//             exmem_mem_read, exmem_mem_write, exmem_branch [, exmem_ovf]
// modport master : the pipeline around the stage (drives ID/EX, reads EX/MEM)
// modport slave  : the execute stage itself
interface ex_stage_muldiv_if #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
);
  logic                  ex_flush;
  logic [WIDTH-1:0]      rd1;
  logic [WIDTH-1:0]      rd2;
  logic [WIDTH-1:0]      sign_ext;
  logic [3:0]            funct_code;
  logic [REG_ADDR_W-1:0] wr_reg_in;
  logic [1:0]            alu_op;
  logic                  alu_src;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  branch;

  logic                  ex_stall;
  logic [WIDTH-1:0]      exmem_result;
  logic [WIDTH-1:0]      exmem_r15;
  logic                  exmem_r15_we;
  logic [WIDTH-1:0]      exmem_store;
  logic                  exmem_zero;
  logic [REG_ADDR_W-1:0] exmem_wr_reg;
  logic                  exmem_mem_to_reg;
  logic                  exmem_reg_write;
  logic                  exmem_mem_read;
  logic                  exmem_mem_write;
  logic                  exmem_branch;
`ifdef OVERFLOW_TRAP_EN
  logic                  exmem_ovf;
`endif

  modport master (
    output ex_flush, rd1, rd2, sign_ext, funct_code, wr_reg_in, alu_op,
           alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
`ifdef OVERFLOW_TRAP_EN
    input  exmem_ovf,
`endif
    input  ex_stall, exmem_result, exmem_r15, exmem_r15_we, exmem_store,
           exmem_zero, exmem_wr_reg, exmem_mem_to_reg, exmem_reg_write,
           exmem_mem_read, exmem_mem_write, exmem_branch
  );

  modport slave (
    input  ex_flush, rd1, rd2, sign_ext, funct_code, wr_reg_in, alu_op,
           alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch,
`ifdef OVERFLOW_TRAP_EN
    output exmem_ovf,
`endif
    output ex_stall, exmem_result, exmem_r15, exmem_r15_we, exmem_store,
           exmem_zero, exmem_wr_reg, exmem_mem_to_reg, exmem_reg_write,
           exmem_mem_read, exmem_mem_write, exmem_branch
  );
endinterface

// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: execute stage with EX/MEM pipeline register.
//   Single-cycle ALU / shift / compare ops, plus an iterative unsigned
//   MUL (shift-add) and DIV (restoring) engine taking WIDTH iterations.
//   While the engine runs, ex_stall holds the upstream stages and EX/MEM
//   receives bubbles. MUL/DIV write lo/quotient to the destination register
//   and hi/remainder to R15 (exmem_r15 + exmem_r15_we).
//
// Optional feature macro: OVERFLOW_TRAP_EN
//   defined   : exmem_ovf flags signed overflow of ADD/SUB and suppresses
//               the register write of that instruction.
//   undefined : ADD/SUB wrap silently.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : ex_stage_muldiv_if.slave (ID/EX inputs, EX/MEM outputs, ex_stall)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | single-cycle ops pass straight to EX/MEM; MUL/DIV launch here
// BUSY  | engine iterating; cnt_q counts 0..WIDTH-1, last one writes result
module ex_stage_muldiv #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input logic              clk,
  input logic              rst,
  ex_stage_muldiv_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OUT_BUBBLE = 2'd0,
    OUT_ALU    = 2'd1,
    OUT_DONE   = 2'd2
  } out_sel_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_AND = 4'b0010;
  localparam logic [3:0] F_OR  = 4'b0011;
  localparam logic [3:0] F_MUL = 4'b0100;
  localparam logic [3:0] F_DIV = 4'b0101;
  localparam logic [3:0] F_SLL = 4'b1000;
  localparam logic [3:0] F_SRL = 4'b1001;
  localparam logic [3:0] F_ROL = 4'b1010;
  localparam logic [3:0] F_ROR = 4'b1011;

  state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  out_sel_t out_sel;
  logic     start;
  logic     iterate;
  logic     stall;

  // engine: acc_hi holds partial product / remainder, acc_lo holds
  // multiplier / dividend bits being consumed, opnd is the fixed operand
  logic [WIDTH-1:0]      acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]      acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]      opnd_q, opnd_d;
  logic                  is_div_q, is_div_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [WIDTH-1:0]      step_hi, step_lo;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_wr_ok;
  logic             is_muldiv;
  logic             is_div_op;
  logic [3:0]       sh;
  logic [CNT_W:0]   sh_inv;
  logic             ovf_kill;

  logic [WIDTH-1:0]      res_d, r15_d, store_d;
  logic                  r15_we_d, zero_d;
  logic [REG_ADDR_W-1:0] wr_d;
  logic                  m2r_d, rw_d, mr_d, mw_d, br_d;

  logic [WIDTH-1:0]      res_q, r15_q, store_q;
  logic                  r15_we_q, zero_q;
  logic [REG_ADDR_W-1:0] wr_q;
  logic                  m2r_q, rw_q, mr_q, mw_q, br_q;

  // ---------------------------------------------------------------- ALU
  assign op_b      = bus.alu_src ? bus.sign_ext : bus.rd2;
  assign sh        = op_b[3:0];
  // complementary shift for rotates; a shift by WIDTH yields 0, so sh==0
  // degenerates cleanly to the unrotated value
  assign sh_inv    = (CNT_W+1)'(WIDTH) - {{(CNT_W-3){1'b0}}, sh};
  assign is_muldiv = (bus.alu_op == 2'b10) &&
                     ((bus.funct_code == F_MUL) || (bus.funct_code == F_DIV));
  assign is_div_op = (bus.funct_code == F_DIV);

  always_comb begin
    alu_res   = '0;
    alu_wr_ok = 1'b1;
    case (bus.alu_op)
      2'b00: alu_res = bus.rd1 + bus.sign_ext;
      2'b01: alu_res = bus.rd1 - op_b;
      2'b10: begin
        case (bus.funct_code)
          F_ADD: alu_res = bus.rd1 + op_b;
          F_SUB: alu_res = bus.rd1 - op_b;
          F_AND: alu_res = bus.rd1 & op_b;
          F_OR:  alu_res = bus.rd1 | op_b;
          F_MUL, F_DIV: alu_res = '0;
          F_SLL: alu_res = bus.rd1 << sh;
          F_SRL: alu_res = bus.rd1 >> sh;
          F_ROL: alu_res = (bus.rd1 << sh) | (bus.rd1 >> sh_inv);
          F_ROR: alu_res = (bus.rd1 >> sh) | (bus.rd1 << sh_inv);
          default: begin
            alu_res   = '0;
            alu_wr_ok = 1'b0;
          end
        endcase
      end
      default: alu_res = bus.sign_ext;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic             alu_ovf;
  logic             is_add, is_sub;
  logic [WIDTH-1:0] ovf_b;

  always_comb begin
    is_add = 1'b0;
    is_sub = 1'b0;
    ovf_b  = op_b;
    case (bus.alu_op)
      2'b00: begin
        is_add = 1'b1;
        ovf_b  = bus.sign_ext;
      end
      2'b01: is_sub = 1'b1;
      2'b10: begin
        is_add = (bus.funct_code == F_ADD);
        is_sub = (bus.funct_code == F_SUB);
      end
      default: ;
    endcase
  end

  // operands of equal sign (ADD) or opposite sign (SUB) overflow when the
  // result sign differs from operand A
  assign alu_ovf = (alu_res[WIDTH-1] != bus.rd1[WIDTH-1]) &&
                   ((is_add && (bus.rd1[WIDTH-1] == ovf_b[WIDTH-1])) ||
                    (is_sub && (bus.rd1[WIDTH-1] != ovf_b[WIDTH-1])));
  assign ovf_kill = alu_ovf;
`else
  assign ovf_kill = 1'b0;
`endif

  // ------------------------------------------------------- engine step
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH-1:0] div_trial;
  logic             div_ge;

  always_comb begin
    mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge     = (div_rem_sh >= {1'b0, opnd_q});
    // when div_ge holds the true difference is below 2^WIDTH, so the
    // truncated subtraction is exact
    div_trial  = div_rem_sh[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_trial : div_rem_sh[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    wr_reg_d = wr_reg_q;
    if (start) begin
      acc_hi_d = '0;
      acc_lo_d = is_div_op ? bus.rd1 : op_b;
      opnd_d   = is_div_op ? op_b : bus.rd1;
      is_div_d = is_div_op;
      wr_reg_d = bus.wr_reg_in;
    end else if (iterate) begin
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
    end
  end

  // --------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_sel = OUT_BUBBLE;
    start   = 1'b0;
    iterate = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ex_flush) begin
          out_sel = OUT_BUBBLE;
        end else if (is_muldiv) begin
          stall   = 1'b1;
          start   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          out_sel = OUT_ALU;
        end
      end
      BUSY: begin
        // dropping stall on the last iteration lets ID/EX advance on the
        // same edge that writes the result
        stall = (cnt_q != CNT_LAST);
        if (bus.ex_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          out_sel = OUT_DONE;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          iterate = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------ EX/MEM select
  always_comb begin
    res_d    = '0;
    r15_d    = '0;
    r15_we_d = 1'b0;
    store_d  = '0;
    zero_d   = 1'b0;
    wr_d     = '0;
    m2r_d    = 1'b0;
    rw_d     = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    br_d     = 1'b0;
    case (out_sel)
      OUT_ALU: begin
        res_d   = alu_res;
        zero_d  = (alu_res == '0);
        store_d = bus.rd2;
        wr_d    = bus.wr_reg_in;
        m2r_d   = bus.mem_to_reg;
        rw_d    = bus.reg_write & alu_wr_ok & ~ovf_kill;
        mr_d    = bus.mem_read;
        mw_d    = bus.mem_write;
        br_d    = bus.branch;
      end
      OUT_DONE: begin
        res_d    = step_lo;
        r15_d    = step_hi;
        r15_we_d = 1'b1;
        zero_d   = (step_lo == '0);
        wr_d     = wr_reg_q;
        rw_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      wr_reg_q <= '0;
      res_q    <= '0;
      r15_q    <= '0;
      r15_we_q <= 1'b0;
      store_q  <= '0;
      zero_q   <= 1'b0;
      wr_q     <= '0;
      m2r_q    <= 1'b0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      wr_reg_q <= wr_reg_d;
      res_q    <= res_d;
      r15_q    <= r15_d;
      r15_we_q <= r15_we_d;
      store_q  <= store_d;
      zero_q   <= zero_d;
      wr_q     <= wr_d;
      m2r_q    <= m2r_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      br_q     <= br_d;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= (out_sel == OUT_ALU) && alu_ovf;
  end
  assign bus.exmem_ovf = ovf_q;
`endif

  assign bus.ex_stall         = stall;
  assign bus.exmem_result     = res_q;
  assign bus.exmem_r15        = r15_q;
  assign bus.exmem_r15_we     = r15_we_q;
  assign bus.exmem_store      = store_q;
  assign bus.exmem_zero       = zero_q;
  assign bus.exmem_wr_reg     = wr_q;
  assign bus.exmem_mem_to_reg = m2r_q;
  assign bus.exmem_reg_write  = rw_q;
  assign bus.exmem_mem_read   = mr_q;
  assign bus.exmem_mem_write  = mw_q;
  assign bus.exmem_branch     = br_q;

endmodule
